// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the RV64I pipeline control logic.
//   fwd_sel_e   : Execute-stage operand source select
//   hz_state_e  : hazard controller memory-wait FSM states
//   DEF_REG_AW  : default register-index width
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_e;

endpackage : core_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count enable
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count register: clear has priority, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: operand forwarding for the Execute stage,
// load-use stall, branch-redirect flush and global stall during data-memory
// wait states, with a wait watchdog and saturating performance counters.
//   clk, rst                      : clock, synchronous active-high reset
//   Rs_D / Rs_E                   : packed source indices (operand i at i*REG_AW)
//   Rd_E/M/W, RegWrite_E/M/W      : destination index and write enable per stage
//   Load_E, Load_M                : stage holds a load
//   MemReq_M, mem_ready_M         : data-memory request / completion
//   PCSrc_E                       : taken redirect resolved in E
//   Forward_E                     : 2-bit source select per operand
//   Stall_F/D/E/M, Flush_D/E/W    : pipeline register hold / clear
//   mem_timeout                   : sticky watchdog flag
//   stall_cnt, flush_cnt          : saturating event counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   Rs_D,
    input  logic [NUM_SRC*REG_AW-1:0]   Rs_E,
    input  logic [REG_AW-1:0]           Rd_E,
    input  logic [REG_AW-1:0]           Rd_M,
    input  logic [REG_AW-1:0]           Rd_W,
    input  logic                        RegWrite_E,
    input  logic                        RegWrite_M,
    input  logic                        RegWrite_W,
    input  logic                        Load_E,
    input  logic                        Load_M,
    input  logic                        MemReq_M,
    input  logic                        mem_ready_M,
    input  logic                        PCSrc_E,
    output logic [NUM_SRC*2-1:0]        Forward_E,
    output logic                        Stall_F,
    output logic                        Stall_D,
    output logic                        Stall_E,
    output logic                        Stall_M,
    output logic                        Flush_D,
    output logic                        Flush_E,
    output logic                        Flush_W,
    output logic                        mem_timeout,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    // Wait counter is wide enough to hold TIMEOUT itself (its saturation point).
    localparam int                 WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]  WCNT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0]  WCNT_TRIP = WCNT_W'(TIMEOUT - 1);

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic               w_mem_wait;
    logic               w_lu_stall;
    logic [NUM_SRC-1:0] w_lu_hit;
    logic [WCNT_W-1:0]  w_wcnt;
    logic               w_wcnt_clr;
    logic               w_wcnt_inc;
    logic               w_stall_inc;
    logic               w_flush_inc;
    logic               r_mem_timeout;

    assign w_mem_wait = MemReq_M & ~mem_ready_M;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] w_rs_e;
        logic [REG_AW-1:0] w_rs_d;
        fwd_sel_e          w_sel;

        assign w_rs_e = Rs_E[g*REG_AW +: REG_AW];
        assign w_rs_d = Rs_D[g*REG_AW +: REG_AW];

        // Register x0 is never a real dependency, so zero indices never match.
        assign w_lu_hit[g] = (w_rs_d != {REG_AW{1'b0}}) && (w_rs_d == Rd_E);

        // Operand source select: M beats W; a load in M has no data to forward yet.
        always_comb begin
            w_sel = FWD_RF;
            if (rst || (w_rs_e == {REG_AW{1'b0}})) begin
                w_sel = FWD_RF;
            end else if (RegWrite_M && (Rd_M == w_rs_e) && !Load_M) begin
                w_sel = FWD_M;
            end else if (RegWrite_W && (Rd_W == w_rs_e)) begin
                w_sel = FWD_W;
            end else begin
                w_sel = FWD_RF;
            end
        end

        assign Forward_E[2*g +: 2] = w_sel;
    end

    assign w_lu_stall = Load_E & RegWrite_E & (Rd_E != {REG_AW{1'b0}}) & (|w_lu_hit);

    // Stall/flush priority: reset, memory wait, redirect, load-use.
    // A memory wait holds E, so a pending redirect stays visible until it can act.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (rst) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
            Flush_W = 1'b1;
        end else if (w_mem_wait) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (w_lu_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end else begin
            Stall_F = 1'b0;
        end
    end

    // Memory-wait FSM next state; WAIT also ends if the request is withdrawn.
    always_comb begin
        w_state_nxt = HZ_RUN;
        case (r_state)
            HZ_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = HZ_WAIT;
                end else begin
                    w_state_nxt = HZ_RUN;
                end
            end
            HZ_WAIT: begin
                if (mem_ready_M || !MemReq_M) begin
                    w_state_nxt = HZ_RUN;
                end else begin
                    w_state_nxt = HZ_WAIT;
                end
            end
            default: w_state_nxt = HZ_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter counts every cycle spent waiting, including the first one
    // (still in RUN), and restarts whenever the FSM lands in RUN.
    assign w_wcnt_clr = rst | (w_state_nxt == HZ_RUN);
    assign w_wcnt_inc = (w_state_nxt == HZ_WAIT) & (w_wcnt != WCNT_MAX);

    sat_counter #(.W(WCNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (w_wcnt_clr),
        .inc   (w_wcnt_inc),
        .count (w_wcnt)
    );

    // Sticky watchdog: trips after TIMEOUT consecutive wait cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_timeout <= 1'b0;
        end else if (w_mem_wait && (w_wcnt == WCNT_TRIP)) begin
            r_mem_timeout <= 1'b1;
        end else begin
            r_mem_timeout <= r_mem_timeout;
        end
    end

    assign mem_timeout = r_mem_timeout;

    // A redirect is counted only in the cycle it actually flushes.
    assign w_stall_inc = Stall_F;
    assign w_flush_inc = ~rst & PCSrc_E & ~w_mem_wait;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed vectors for hazard_ctrl (NUM_SRC=2, TIMEOUT=4, CNT_W=4). Each vector
// is one clock cycle; its hand-computed expectation is queued when driven and
// popped by the monitor at the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import core_pkg::*;

    localparam int NS  = 2;
    localparam int AW  = 5;
    localparam int TO  = 4;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*AW-1:0]  rs_d, rs_e;
    logic [AW-1:0]     rd_e, rd_m, rd_w;
    logic              rw_e, rw_m, rw_w, ld_e, ld_m, mreq, mrdy, pc;
    logic [NS*2-1:0]   fwd;
    logic              st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w, tmo;
    logic [CW-1:0]     scnt, fcnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Rs_D(rs_d), .Rs_E(rs_e),
        .Rd_E(rd_e), .Rd_M(rd_m), .Rd_W(rd_w),
        .RegWrite_E(rw_e), .RegWrite_M(rw_m), .RegWrite_W(rw_w),
        .Load_E(ld_e), .Load_M(ld_m), .MemReq_M(mreq), .mem_ready_M(mrdy),
        .PCSrc_E(pc), .Forward_E(fwd),
        .Stall_F(st_f), .Stall_D(st_d), .Stall_E(st_e), .Stall_M(st_m),
        .Flush_D(fl_d), .Flush_E(fl_e), .Flush_W(fl_w),
        .mem_timeout(tmo), .stall_cnt(scnt), .flush_cnt(fcnt)
    );

    // ctl packing: {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0000111;
    localparam logic [6:0] C_MW   = 7'b1111001;
    localparam logic [6:0] C_PC   = 7'b0000110;
    localparam logic [6:0] C_LU   = 7'b1100010;

    typedef struct {
        logic [3:0] fwd;
        logic [6:0] ctl;
        logic       tmo;
        logic [3:0] scnt;
        logic [3:0] fcnt;
        int         id;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         vec_id = 0;
    logic [3:0] exp_scnt = 4'd0;
    logic [3:0] exp_fcnt = 4'd0;

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec%0d actual %0h required %0h", nm, id, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("forward",  mon_e.id, {4'd0, fwd}, {4'd0, mon_e.fwd});
            chk("ctl",      mon_e.id, {1'b0, st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w}, {1'b0, mon_e.ctl});
            chk("timeout",  mon_e.id, {7'd0, tmo}, {7'd0, mon_e.tmo});
            chk("stallcnt", mon_e.id, {4'd0, scnt}, {4'd0, mon_e.scnt});
            chk("flushcnt", mon_e.id, {4'd0, fcnt}, {4'd0, mon_e.fcnt});
        end
    end

    // Queue one cycle's expectation, advance the counter model, move to next cycle.
    task automatic vec(input logic [3:0] f, input logic [6:0] c, input logic t);
        exp_t e;
        e.fwd = f; e.ctl = c; e.tmo = t; e.scnt = exp_scnt; e.fcnt = exp_fcnt; e.id = vec_id;
        sb_q.push_back(e);
        vec_id++;
        if (rst) begin
            exp_scnt = 4'd0;
            exp_fcnt = 4'd0;
        end else begin
            if (c[6] && (exp_scnt != 4'hF)) exp_scnt = exp_scnt + 4'd1;
            if (pc && !c[3] && (exp_fcnt != 4'hF)) exp_fcnt = exp_fcnt + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        rw_e = 1'b0; rw_m = 1'b0; rw_w = 1'b0; ld_e = 1'b0; ld_m = 1'b0;
        mreq = 1'b0; mrdy = 1'b0; pc = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        // Reset with a live M-forward pattern: everything forced to reset values.
        rs_e[4:0] = 5'd5; rd_m = 5'd5; rw_m = 1'b1;
        vec(4'b0000, C_RST, 1'b0);
        rst = 1'b0;

        // Forwarding: M over W, load in M falls back to W, x0 never forwards.
        rd_w = 5'd5; rw_w = 1'b1;
        vec(4'b0010, C_NONE, 1'b0);
        ld_m = 1'b1;
        vec(4'b0001, C_NONE, 1'b0);
        rs_e[4:0] = 5'd0; rs_e[9:5] = 5'd5;
        vec(4'b0100, C_NONE, 1'b0);
        ld_m = 1'b0; rs_e[4:0] = 5'd9; rd_w = 5'd9;
        vec(4'b1001, C_NONE, 1'b0);

        // Load-use on operand 1: one stall cycle, then load moves to M, then W.
        idle();
        ld_e = 1'b1; rw_e = 1'b1; rd_e = 5'd7; rs_d[9:5] = 5'd7;
        vec(4'b0000, C_LU, 1'b0);
        idle();
        ld_m = 1'b1; rw_m = 1'b1; rd_m = 5'd7;
        vec(4'b0000, C_NONE, 1'b0);
        idle();
        rw_w = 1'b1; rd_w = 5'd7; rs_e[9:5] = 5'd7;
        vec(4'b0100, C_NONE, 1'b0);

        // Redirect beats load-use.
        idle();
        ld_e = 1'b1; rw_e = 1'b1; rd_e = 5'd7; rs_d[9:5] = 5'd7; pc = 1'b1;
        vec(4'b0000, C_PC, 1'b0);
        idle();
        vec(4'b0000, C_NONE, 1'b0);
        // Load writing x0 with x0 sources, and a non-writing load: no stall.
        ld_e = 1'b1; rw_e = 1'b1; rd_e = 5'd0;
        vec(4'b0000, C_NONE, 1'b0);
        rw_e = 1'b0; rd_e = 5'd7; rs_d[4:0] = 5'd7;
        vec(4'b0000, C_NONE, 1'b0);

        // Three wait cycles with a redirect held; redirect acts on the ready cycle.
        idle();
        mreq = 1'b1; pc = 1'b1;
        for (int i = 0; i < 3; i++) vec(4'b0000, C_MW, 1'b0);
        mrdy = 1'b1;
        vec(4'b0000, C_PC, 1'b0);

        // Back-to-back wait: counter restarts, watchdog trips after 4 wait cycles.
        idle();
        mreq = 1'b1;
        for (int i = 0; i < 4; i++) vec(4'b0000, C_MW, 1'b0);
        vec(4'b0000, C_MW, 1'b1);
        mrdy = 1'b1;
        vec(4'b0000, C_NONE, 1'b1);
        idle();
        vec(4'b0000, C_NONE, 1'b1);

        // Drive stall_cnt into saturation at 15.
        ld_e = 1'b1; rw_e = 1'b1; rd_e = 5'd3; rs_d[4:0] = 5'd3;
        for (int i = 0; i < 8; i++) vec(4'b0000, C_LU, 1'b1);
        idle();
        vec(4'b0000, C_NONE, 1'b1);

        // Reset in the middle of a wait, then the wait continues from scratch.
        mreq = 1'b1;
        vec(4'b0000, C_MW, 1'b1);
        vec(4'b0000, C_MW, 1'b1);
        rst = 1'b1;
        vec(4'b0000, C_RST, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) vec(4'b0000, C_MW, 1'b0);
        vec(4'b0000, C_MW, 1'b1);
        mreq = 1'b0;
        vec(4'b0000, C_NONE, 1'b1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
